// File: rtl/fetch_aligner_if.sv
// Instruction-cache request/response bus between the fetch aligner and the icache.
// The master modport is the fetch side; the slave modport is the icache side.
interface fetch_aligner_if;
  logic         icache_req_valid;
  logic         icache_req_ready;
  logic [63:0]  icache_req_addr;
  logic         icache_resp_valid;
  logic [127:0] icache_resp_data;

  modport master (
    output icache_req_valid,
    output icache_req_addr,
    input  icache_req_ready,
    input  icache_resp_valid,
    input  icache_resp_data
  );

  modport slave (
    input  icache_req_valid,
    input  icache_req_addr,
    output icache_req_ready,
    output icache_resp_valid,
    output icache_resp_data
  );
endinterface

// File: rtl/fetch_aligner.sv
// Fetches 16-byte blocks from the icache and compacts the words from the fetch PC onward into slot 0.
// Redirects flush in-flight work; a response already owed by the icache is swallowed via drop_pending.
module fetch_aligner #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_inst,
  input  logic                  redirect_valid,
  input  logic [63:0]           redirect_target,
  input  logic                  mem_stall,
  fetch_aligner_if.master       icache,
  output logic [127:0]          aligned_instr,
  output logic [3:0]            aligned_instr_valid,
  output logic [63:0]           pc
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_RESP = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  state_t       r_state;
  logic [63:0]  r_fetch_pc;
  logic         r_drop_pending;
  logic [2:0]   r_hold_cnt;
  logic         r_req_valid;
  logic [63:0]  r_req_addr;
  logic [127:0] r_aligned_instr;
  logic [3:0]   r_aligned_valid;
  logic [63:0]  r_pc;

  logic [1:0]   w_offset;
  logic [3:0]   w_mask;
  logic [2:0]   w_hold_init;
  logic [127:0] w_shifted;
  logic [63:0]  w_block_addr;
  logic [63:0]  w_next_block;
  logic [63:0]  w_redirect_pc;
  logic         w_lose_resp;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_offset    = r_fetch_pc[3:2];
    w_mask      = 4'b1111;
    w_hold_init = 3'd5;
    case (w_offset)
      2'd0: begin w_mask = 4'b1111; w_hold_init = 3'd5; end
      2'd1: begin w_mask = 4'b0111; w_hold_init = 3'd4; end
      2'd2: begin w_mask = 4'b0011; w_hold_init = 3'd3; end
      2'd3: begin w_mask = 4'b0001; w_hold_init = 3'd2; end
      default: ;
    endcase
    w_shifted     = icache.icache_resp_data >> {w_offset, 5'b0_0000};
    w_block_addr  = {r_fetch_pc[63:4], 4'b0000};
    w_next_block  = {r_fetch_pc[63:4] + 60'd1, 4'b0000};
    w_redirect_pc = redirect_target & ~64'h3;
    // A request the icache has accepted (or is accepting now) will still be answered later.
    w_lose_resp   = ((r_state == S_WAIT_RESP) && !icache.icache_resp_valid) ||
                    ((r_state == S_REQ) && icache.icache_req_ready);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_fetch_pc      <= RESET_PC;
      r_drop_pending  <= 1'b0;
      r_hold_cnt      <= 3'd0;
      r_req_valid     <= 1'b0;
      r_req_addr      <= 64'd0;
      r_aligned_instr <= 128'd0;
      r_aligned_valid <= 4'd0;
      r_pc            <= 64'd0;
    end else begin
      r_aligned_valid <= 4'd0;
      if (r_drop_pending && icache.icache_resp_valid) r_drop_pending <= 1'b0;

      if (redirect_valid) begin
        r_fetch_pc  <= w_redirect_pc;
        r_state     <= S_IDLE;
        r_req_valid <= 1'b0;
        r_hold_cnt  <= 3'd0;
        if (w_lose_resp) r_drop_pending <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (fetch_inst && !mem_stall && !r_drop_pending) begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
              r_req_addr  <= w_block_addr;
            end
          end
          S_REQ: begin
            if (icache.icache_req_ready) begin
              r_state     <= S_WAIT_RESP;
              r_req_valid <= 1'b0;
            end
          end
          S_WAIT_RESP: begin
            if (icache.icache_resp_valid && !r_drop_pending) begin
              r_aligned_instr <= w_shifted;
              r_aligned_valid <= w_mask;
              r_pc            <= r_fetch_pc;
              r_fetch_pc      <= w_next_block;
              r_hold_cnt      <= w_hold_init;
              r_state         <= S_HOLD;
            end
          end
          S_HOLD: begin
            r_hold_cnt <= r_hold_cnt - 3'd1;
            if (r_hold_cnt <= 3'd1) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign icache.icache_req_valid = r_req_valid;
  assign icache.icache_req_addr  = r_req_addr;
  assign aligned_instr           = r_aligned_instr;
  assign aligned_instr_valid     = r_aligned_valid;
  assign pc                      = r_pc;

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner: delivery alignment, hold timing, redirects, stalls and reset.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_fetch_aligner;

  localparam logic [31:0] W0 = 32'h0000_1013;
  localparam logic [31:0] W1 = 32'h1111_2093;
  localparam logic [31:0] W2 = 32'h2222_3113;
  localparam logic [31:0] W3 = 32'h3333_4193;
  localparam logic [127:0] BLOCK = {W3, W2, W1, W0};

  logic         clock = 1'b0;
  logic         reset;
  logic         fetch_inst;
  logic         redirect_valid;
  logic [63:0]  redirect_target;
  logic         mem_stall;
  logic [127:0] aligned_instr;
  logic [3:0]   aligned_instr_valid;
  logic [63:0]  pc;

  int checks = 0;
  int errors = 0;

  fetch_aligner_if u_if ();

  fetch_aligner #(.RESET_PC(64'h8000_0000)) u_dut (
    .clock               (clock),
    .reset               (reset),
    .fetch_inst          (fetch_inst),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .mem_stall           (mem_stall),
    .icache              (u_if),
    .aligned_instr       (aligned_instr),
    .aligned_instr_valid (aligned_instr_valid),
    .pc                  (pc)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset                    = 1'b1;
    fetch_inst               = 1'b0;
    redirect_valid           = 1'b0;
    redirect_target          = 64'd0;
    mem_stall                = 1'b0;
    u_if.icache_req_ready    = 1'b0;
    u_if.icache_resp_valid   = 1'b0;
    u_if.icache_resp_data    = 128'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Ticks until a request is visible, giving up after 20 cycles.
  task automatic wait_req(output int cycles);
    cycles = 0;
    while (!u_if.icache_req_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  // Counts cycles from a delivery until the next request; also checks the valid pulse is one cycle wide.
  task automatic count_to_next_req(input logic [127:0] exp_instr, output int cycles);
    cycles = 0;
    while (!u_if.icache_req_valid && cycles < 20) begin
      tick();
      cycles++;
      if (cycles == 1) begin
        checks++;
        if (aligned_instr_valid !== 4'b0000 || aligned_instr !== exp_instr) begin
          errors++;
          $display("FAIL pulse_width: valid=%b instr=%h, required valid=0000 instr=%h",
                   aligned_instr_valid, aligned_instr, exp_instr);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_inst = 1'b1;
    tick();
    checks++;
    if (u_if.icache_req_valid !== 1'b0 || u_if.icache_req_addr !== 64'd0) begin
      errors++;
      $display("FAIL reset_req: valid=%b addr=%h, required 0 / 0",
               u_if.icache_req_valid, u_if.icache_req_addr);
    end
    checks++;
    if (aligned_instr !== 128'd0 || aligned_instr_valid !== 4'd0 || pc !== 64'd0) begin
      errors++;
      $display("FAIL reset_out: instr=%h valid=%b pc=%h, required all 0",
               aligned_instr, aligned_instr_valid, pc);
    end
  endtask

  task automatic test_basic_fetch();
    int n;
    do_reset();
    fetch_inst = 1'b1;
    u_if.icache_req_ready = 1'b1;
    wait_req(n);
    checks++;
    if (n !== 1 || u_if.icache_req_addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL basic_req: cycles=%0d addr=%h, required 1 / 80000000", n, u_if.icache_req_addr);
    end
    tick();
    checks++;
    if (u_if.icache_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_req_drop: valid=%b, required 0", u_if.icache_req_valid);
    end
    u_if.icache_resp_valid = 1'b1;
    u_if.icache_resp_data  = BLOCK;
    tick();
    u_if.icache_resp_valid = 1'b0;
    checks++;
    if (aligned_instr_valid !== 4'b1111 || aligned_instr !== BLOCK || pc !== 64'h8000_0000) begin
      errors++;
      $display("FAIL basic_deliver: valid=%b instr=%h pc=%h, required 1111 %h 80000000",
               aligned_instr_valid, aligned_instr, pc, BLOCK);
    end
    count_to_next_req(BLOCK, n);
    checks++;
    if (n !== 6 || u_if.icache_req_addr !== 64'h8000_0010) begin
      errors++;
      $display("FAIL basic_hold: cycles=%0d addr=%h, required 6 / 80000010", n, u_if.icache_req_addr);
    end
  endtask

  task automatic test_offset_fetch();
    int n;
    do_reset();
    fetch_inst = 1'b1;
    u_if.icache_req_ready = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 64'h8000_000B;
    tick();
    redirect_valid = 1'b0;
    wait_req(n);
    checks++;
    if (n !== 1 || u_if.icache_req_addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL offset_req: cycles=%0d addr=%h, required 1 / 80000000", n, u_if.icache_req_addr);
    end
    tick();
    u_if.icache_resp_valid = 1'b1;
    u_if.icache_resp_data  = BLOCK;
    tick();
    u_if.icache_resp_valid = 1'b0;
    checks++;
    if (aligned_instr_valid !== 4'b0011 || aligned_instr !== {64'h0, W3, W2} || pc !== 64'h8000_0008) begin
      errors++;
      $display("FAIL offset_deliver: valid=%b instr=%h pc=%h, required 0011 %h 80000008",
               aligned_instr_valid, aligned_instr, pc, {64'h0, W3, W2});
    end
    count_to_next_req({64'h0, W3, W2}, n);
    checks++;
    if (n !== 4 || u_if.icache_req_addr !== 64'h8000_0010) begin
      errors++;
      $display("FAIL offset_hold: cycles=%0d addr=%h, required 4 / 80000010", n, u_if.icache_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    int seen;
    do_reset();
    fetch_inst = 1'b1;
    u_if.icache_req_ready = 1'b1;
    wait_req(n);
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 64'h100;
    tick();
    redirect_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (u_if.icache_req_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL drop_no_req: req cycles=%0d, required 0", seen);
    end
    u_if.icache_resp_valid = 1'b1;
    u_if.icache_resp_data  = BLOCK;
    tick();
    u_if.icache_resp_valid = 1'b0;
    checks++;
    if (aligned_instr_valid !== 4'b0000 || u_if.icache_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_discard: valid=%b req=%b, required 0000 / 0",
               aligned_instr_valid, u_if.icache_req_valid);
    end
    wait_req(n);
    checks++;
    if (n !== 1 || u_if.icache_req_addr !== 64'h100) begin
      errors++;
      $display("FAIL drop_restart: cycles=%0d addr=%h, required 1 / 100", n, u_if.icache_req_addr);
    end
  endtask

  task automatic test_redirect_coincident();
    int n;
    do_reset();
    fetch_inst = 1'b1;
    u_if.icache_req_ready = 1'b1;
    wait_req(n);
    tick();
    u_if.icache_resp_valid = 1'b1;
    u_if.icache_resp_data  = BLOCK;
    redirect_valid  = 1'b1;
    redirect_target = 64'h20C;
    tick();
    u_if.icache_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (aligned_instr_valid !== 4'b0000) begin
      errors++;
      $display("FAIL coinc_discard: valid=%b, required 0000", aligned_instr_valid);
    end
    wait_req(n);
    checks++;
    if (n !== 1 || u_if.icache_req_addr !== 64'h200) begin
      errors++;
      $display("FAIL coinc_req: cycles=%0d addr=%h, required 1 / 200", n, u_if.icache_req_addr);
    end
    tick();
    u_if.icache_resp_valid = 1'b1;
    u_if.icache_resp_data  = BLOCK;
    tick();
    u_if.icache_resp_valid = 1'b0;
    checks++;
    if (aligned_instr_valid !== 4'b0001 || aligned_instr !== {96'h0, W3} || pc !== 64'h20C) begin
      errors++;
      $display("FAIL coinc_deliver: valid=%b instr=%h pc=%h, required 0001 %h 20c",
               aligned_instr_valid, aligned_instr, pc, {96'h0, W3});
    end
  endtask

  task automatic test_stall_and_ready();
    int seen;
    do_reset();
    fetch_inst = 1'b1;
    mem_stall  = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (u_if.icache_req_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL stall_idle: req cycles=%0d, required 0", seen);
    end
    mem_stall = 1'b0;
    tick();
    checks++;
    if (u_if.icache_req_valid !== 1'b1 || u_if.icache_req_addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL stall_release: valid=%b addr=%h, required 1 / 80000000",
               u_if.icache_req_valid, u_if.icache_req_addr);
    end
    mem_stall = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (u_if.icache_req_valid === 1'b1 && u_if.icache_req_addr === 64'h8000_0000) seen++;
    end
    checks++;
    if (seen !== 3) begin
      errors++;
      $display("FAIL ready_low_stable: stable cycles=%0d, required 3", seen);
    end
    u_if.icache_req_ready = 1'b1;
    tick();
    checks++;
    if (u_if.icache_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_accept: valid=%b, required 0", u_if.icache_req_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    fetch_inst = 1'b1;
    u_if.icache_req_ready = 1'b1;
    wait_req(n);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch_inst = 1'b0;
    checks++;
    if (u_if.icache_req_valid !== 1'b0 || aligned_instr_valid !== 4'd0) begin
      errors++;
      $display("FAIL midreset_state: req=%b valid=%b, required 0 / 0000",
               u_if.icache_req_valid, aligned_instr_valid);
    end
    u_if.icache_resp_valid = 1'b1;
    u_if.icache_resp_data  = BLOCK;
    tick();
    u_if.icache_resp_valid = 1'b0;
    checks++;
    if (aligned_instr_valid !== 4'd0 || aligned_instr !== 128'd0) begin
      errors++;
      $display("FAIL midreset_ignore: valid=%b instr=%h, required 0000 / 0",
               aligned_instr_valid, aligned_instr);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic_fetch();
    test_offset_fetch();
    test_redirect_wait();
    test_redirect_coincident();
    test_stall_and_ready();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
